// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants, typedefs and trellis helpers for the K=3 rate-1/2 Viterbi decoder
//
// Purpose: code constants (generators 7,5 octal), default widths and
//          trellis table helpers used by the ACS stage and its butterflies.
// Ports:   none (package).
package viterbi_pkg;

   localparam int NUM_STATES = 4;
   localparam int BM_W_DEF   = 2;
   localparam int PM_W_DEF   = 6;

   // Generator taps over the encoder window {u, u[n-1], u[n-2]}.
   localparam logic [2:0] G0 = 3'b111;
   localparam logic [2:0] G1 = 3'b101;

   typedef logic [BM_W_DEF-1:0] bm_t;
   typedef logic [PM_W_DEF-1:0] pm_t;
   typedef logic [1:0]          state_t;

   // Expected code symbol {c0,c1} when input u is shifted into state s.
   function automatic logic [1:0] exp_sym(input state_t s, input logic u);
      logic [2:0] window;
      window = {u, s};
      return {^(window & G0), ^(window & G1)};
   endfunction

   // Predecessor of next-state ns: ns={u,p} is reached from {p,sel}.
   function automatic state_t pred_of(input state_t ns, input logic sel);
      return {ns[0], sel};
   endfunction

endpackage

// File: rtl/viterbi_acs_butterfly.sv
// rtl/viterbi_acs_butterfly.sv - two ACS nodes sharing the predecessor pair {P,0}/{P,1}
//
// Purpose: computes the saturating add-compare-select for next states
//          {0,P} (lo) and {1,P} (hi) from predecessors 2P (a) and 2P+1 (b).
// Ports:
//   pm_a, pm_b      in   PM_W       metrics of predecessors 2P and 2P+1
//   bm              in   4 x BM_W   branch metrics indexed by symbol {c0,c1}
//   pm_lo, pm_hi    out  PM_W       selected metrics for next states P and 2+P
//   dec_lo, dec_hi  out  1          decision (LSB of chosen predecessor)
module viterbi_acs_butterfly
   import viterbi_pkg::*;
#(
   parameter int P    = 0,
   parameter int BM_W = BM_W_DEF,
   parameter int PM_W = PM_W_DEF
)(
   input  logic [PM_W-1:0]        pm_a,
   input  logic [PM_W-1:0]        pm_b,
   input  logic [3:0][BM_W-1:0]   bm,
   output logic [PM_W-1:0]        pm_lo,
   output logic [PM_W-1:0]        pm_hi,
   output logic                   dec_lo,
   output logic                   dec_hi
);

   localparam logic [1:0] SYM_A_LO = exp_sym(2'(2*P),     1'b0);
   localparam logic [1:0] SYM_B_LO = exp_sym(2'(2*P + 1), 1'b0);
   localparam logic [1:0] SYM_A_HI = exp_sym(2'(2*P),     1'b1);
   localparam logic [1:0] SYM_B_HI = exp_sym(2'(2*P + 1), 1'b1);

   function automatic logic [PM_W-1:0] add_sat(input logic [PM_W-1:0] pm,
                                               input logic [BM_W-1:0] b);
      logic [PM_W:0] sum;
      sum = {1'b0, pm} + (PM_W+1)'(b);
      return sum[PM_W] ? '1 : sum[PM_W-1:0];
   endfunction

   logic [PM_W-1:0] cand_a_lo, cand_b_lo, cand_a_hi, cand_b_hi;

   always_comb begin
      cand_a_lo = add_sat(pm_a, bm[SYM_A_LO]);
      cand_b_lo = add_sat(pm_b, bm[SYM_B_LO]);
      cand_a_hi = add_sat(pm_a, bm[SYM_A_HI]);
      cand_b_hi = add_sat(pm_b, bm[SYM_B_HI]);
      // Strict compare: ties keep the lower-index predecessor.
      dec_lo = (cand_b_lo < cand_a_lo);
      dec_hi = (cand_b_hi < cand_a_hi);
      pm_lo  = dec_lo ? cand_b_lo : cand_a_lo;
      pm_hi  = dec_hi ? cand_b_hi : cand_a_hi;
   end

endmodule

// File: rtl/viterbi_acs_unit.sv
// rtl/viterbi_acs_unit.sv - path-metric ACS stage, rate 1/2, K=3, generators 7,5
//
// Purpose: on each path_enable strobe combines four branch metrics with the
//          stored state metrics, registers normalised new metrics and emits a
//          4-bit survivor decision word one cycle later.
// Optional feature: define ACS_BEST_STATE_EN to register best_state as the
//          argmin of the new metrics; otherwise best_state is tied to 0.
// Ports:
//   CLK, RST                    in   clock (rising), async reset active-low
//   frame_start                 in   re-initialise metrics and step counter
//   path_enable                 in   perform one ACS step
//   bm_00, bm_01, bm_10, bm_11  in   branch metrics per expected symbol
//   survivor                    out  decision per next state
//   survivor_valid              out  pulse, survivor holds the step result
//   frame_done                  out  pulse with the last step of a frame
//   best_state                  out  start state for traceback
module viterbi_acs_unit
   import viterbi_pkg::*;
#(
   parameter int BM_W    = BM_W_DEF,
   parameter int PM_W    = PM_W_DEF,
   parameter int INIT_PM = 16,
   parameter int SEQ_NUM = 64
)(
   input  logic            CLK,
   input  logic            RST,
   input  logic            frame_start,
   input  logic            path_enable,
   input  logic [BM_W-1:0] bm_00,
   input  logic [BM_W-1:0] bm_01,
   input  logic [BM_W-1:0] bm_10,
   input  logic [BM_W-1:0] bm_11,
   output logic [3:0]      survivor,
   output logic            survivor_valid,
   output logic            frame_done,
   output logic [1:0]      best_state
);

   localparam int CNT_W = (SEQ_NUM > 1) ? $clog2(SEQ_NUM) : 1;
   localparam logic [PM_W-1:0] HALF = PM_W'(1) << (PM_W-1);

   logic [PM_W-1:0]      pm_q   [NUM_STATES];
   logic [PM_W-1:0]      src    [NUM_STATES];
   logic [PM_W-1:0]      acs    [NUM_STATES];
   logic [PM_W-1:0]      nxt    [NUM_STATES];
   logic [3:0]           dec;
   logic [3:0][BM_W-1:0] bm_vec;
   logic                 all_high;
   logic [CNT_W-1:0]     step_cnt;
   logic [CNT_W-1:0]     cur_step;
   logic                 last_step;

   function automatic logic [PM_W-1:0] init_pm(input int s);
      return (s == 0) ? '0 : PM_W'(INIT_PM);
   endfunction

   assign bm_vec = {bm_11, bm_10, bm_01, bm_00};

   // A coincident frame_start makes this step read the init metrics.
   always_comb begin
      for (int i = 0; i < NUM_STATES; i++) begin
         src[i] = frame_start ? init_pm(i) : pm_q[i];
      end
   end

   viterbi_acs_butterfly #(.P(0), .BM_W(BM_W), .PM_W(PM_W)) u_bfly0 (
      .pm_a   (src[0]),
      .pm_b   (src[1]),
      .bm     (bm_vec),
      .pm_lo  (acs[0]),
      .pm_hi  (acs[2]),
      .dec_lo (dec[0]),
      .dec_hi (dec[2])
   );

   viterbi_acs_butterfly #(.P(1), .BM_W(BM_W), .PM_W(PM_W)) u_bfly1 (
      .pm_a   (src[2]),
      .pm_b   (src[3]),
      .bm     (bm_vec),
      .pm_lo  (acs[1]),
      .pm_hi  (acs[3]),
      .dec_lo (dec[1]),
      .dec_hi (dec[3])
   );

   // When every metric has its MSB set, clearing it subtracts HALF from all.
   always_comb begin
      all_high = acs[0][PM_W-1] & acs[1][PM_W-1] & acs[2][PM_W-1] & acs[3][PM_W-1];
      for (int i = 0; i < NUM_STATES; i++) begin
         nxt[i] = all_high ? (acs[i] & ~HALF) : acs[i];
      end
   end

   assign cur_step  = frame_start ? '0 : step_cnt;
   assign last_step = (cur_step == CNT_W'(SEQ_NUM - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < NUM_STATES; i++) begin
            pm_q[i] <= init_pm(i);
         end
         survivor       <= '0;
         survivor_valid <= 1'b0;
         frame_done     <= 1'b0;
         step_cnt       <= '0;
      end else begin
         survivor_valid <= 1'b0;
         frame_done     <= 1'b0;
         if (path_enable) begin
            survivor       <= dec;
            survivor_valid <= 1'b1;
            if (last_step) begin
               frame_done <= 1'b1;
               step_cnt   <= '0;
               for (int i = 0; i < NUM_STATES; i++) begin
                  pm_q[i] <= init_pm(i);
               end
            end else begin
               step_cnt <= cur_step + CNT_W'(1);
               for (int i = 0; i < NUM_STATES; i++) begin
                  pm_q[i] <= nxt[i];
               end
            end
         end else if (frame_start) begin
            step_cnt <= '0;
            for (int i = 0; i < NUM_STATES; i++) begin
               pm_q[i] <= init_pm(i);
            end
         end
      end
   end

`ifdef ACS_BEST_STATE_EN
   logic [1:0]      best_nxt;
   logic [PM_W-1:0] best_val;

   // Argmin of the step's metrics, lowest index on ties. Normalisation
   // shifts all metrics equally, so ordering is unaffected.
   always_comb begin
      best_nxt = 2'd0;
      best_val = nxt[0];
      for (int i = 1; i < NUM_STATES; i++) begin
         if (nxt[i] < best_val) begin
            best_nxt = 2'(i);
            best_val = nxt[i];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         best_state <= 2'd0;
      end else if (path_enable) begin
         best_state <= best_nxt;
      end else if (frame_start) begin
         best_state <= 2'd0;
      end
   end
`else
   assign best_state = 2'b00;
`endif

endmodule

// File: tb/tb_viterbi_acs_unit.sv
// tb/tb_viterbi_acs_unit.sv - scoreboard bench for viterbi_acs_unit against a trellis reference model
module tb_viterbi_acs_unit;

   localparam int PM_MAX  = 63;
   localparam int HALF    = 32;
   localparam int INIT_PM = 16;
   localparam int SEQ_NUM = 64;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       frame_start = 1'b0;
   logic       path_enable = 1'b0;
   logic [1:0] bm_00 = '0, bm_01 = '0, bm_10 = '0, bm_11 = '0;
   logic [3:0] survivor;
   logic       survivor_valid;
   logic       frame_done;
   logic [1:0] best_state;

   viterbi_acs_unit dut (
      .CLK            (CLK),
      .RST            (RST),
      .frame_start    (frame_start),
      .path_enable    (path_enable),
      .bm_00          (bm_00),
      .bm_01          (bm_01),
      .bm_10          (bm_10),
      .bm_11          (bm_11),
      .survivor       (survivor),
      .survivor_valid (survivor_valid),
      .frame_done     (frame_done),
      .best_state     (best_state)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [3:0]      surv;
      logic            fd;
      logic [1:0]      best;
      logic [3:0][5:0] pm;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         n_checks = 0;
   int         n_errors = 0;
   int         n_valid  = 0;
   int         n_done   = 0;
   logic [3:0] hold_surv = '0;

   int     mb[4];
   longint ub[4];
   int     mstep;
   int     norm_events = 0;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int pm_vec();
      return int'({dut.pm_q[3], dut.pm_q[2], dut.pm_q[1], dut.pm_q[0]});
   endfunction

   function automatic int sat(input int x);
      return (x > PM_MAX) ? PM_MAX : x;
   endfunction

   // Encoder output for input u entering state s={u[n-1],u[n-2]}, as 2*c0+c1.
   function automatic int sym_of(input int s, input int u);
      int c0, c1;
      c0 = (u + (s / 2) + (s % 2)) % 2;
      c1 = (u + (s % 2)) % 2;
      return 2 * c0 + c1;
   endfunction

   function automatic int hd(input int a, input int b);
      int x;
      x = a ^ b;
      return (x & 1) + ((x >> 1) & 1);
   endfunction

   task automatic model_init();
      mb = '{0, INIT_PM, INIT_PM, INIT_PM};
      ub = '{0, INIT_PM, INIT_PM, INIT_PM};
      mstep = 0;
   endtask

   // Drive one cycle of stimulus (called at posedge+1) and predict its result.
   task automatic issue(input bit fs, input bit pe, input int b00, input int b01,
                        input int b10, input int b11);
      int         bm[4];
      int         nb[4];
      longint     nu[4];
      logic [3:0] surv;
      int         best;
      int         ca, cb;
      longint     uca, ucb;
      exp_t       e;
      bm = '{b00, b01, b10, b11};
      frame_start = fs;
      path_enable = pe;
      bm_00 = 2'(b00); bm_01 = 2'(b01); bm_10 = 2'(b10); bm_11 = 2'(b11);
      if (fs) model_init();
      if (pe) begin
         for (int ns = 0; ns < 4; ns++) begin
            int u, pa, pb;
            u  = ns / 2;
            pa = 2 * (ns % 2);
            pb = pa + 1;
            ca  = sat(mb[pa] + bm[sym_of(pa, u)]);
            cb  = sat(mb[pb] + bm[sym_of(pb, u)]);
            nb[ns] = (cb < ca) ? cb : ca;
            uca = ub[pa] + bm[sym_of(pa, u)];
            ucb = ub[pb] + bm[sym_of(pb, u)];
            surv[ns] = (ucb < uca);
            nu[ns] = surv[ns] ? ucb : uca;
         end
         if (nb[0] >= HALF && nb[1] >= HALF && nb[2] >= HALF && nb[3] >= HALF) begin
            for (int i = 0; i < 4; i++) nb[i] -= HALF;
            norm_events++;
         end
         best = 0;
         for (int i = 1; i < 4; i++) if (nb[i] < nb[best]) best = i;
         e.fd = (mstep == SEQ_NUM - 1);
         if (e.fd) model_init();
         else begin
            mb = nb;
            ub = nu;
            mstep++;
         end
         e.surv = surv;
`ifdef ACS_BEST_STATE_EN
         e.best = 2'(best);
`else
         e.best = 2'd0;
`endif
         for (int i = 0; i < 4; i++) e.pm[i] = 6'(mb[i]);
         sb.push_back(e);
      end
      @(posedge CLK);
      #1;
      frame_start = 1'b0;
      path_enable = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic rand_step();
      int r;
      r = int'($urandom_range(0, 3));
      issue(0, 1, hd(r, 0), hd(r, 1), hd(r, 2), hd(r, 3));
   endtask

   always @(negedge CLK) begin
      if (!RST) begin
         hold_surv = '0;
      end else if (survivor_valid) begin
         n_valid++;
         if (frame_done) n_done++;
         if (sb.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("survivor", int'(survivor), int'(mon_e.surv));
            check("frame_done", int'(frame_done), int'(mon_e.fd));
            check("best_state", int'(best_state), int'(mon_e.best));
            check("pm_regs", pm_vec(), int'(mon_e.pm));
            hold_surv = mon_e.surv;
         end
      end else begin
         check("survivor_hold", int'(survivor), int'(hold_surv));
         check("frame_done_idle", int'(frame_done), 0);
      end
   end

   initial begin
      int v0, d0, ne0;
      int syms[4];
      int truth[4];
      syms  = '{3, 2, 0, 1};
      truth = '{2, 1, 2, 3};

      // Reset state
      idle(2);
      check("rst_survivor", int'(survivor), 0);
      check("rst_valid", int'(survivor_valid), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_best_state", int'(best_state), 0);
      check("rst_pm", pm_vec(), (INIT_PM << 18) | (INIT_PM << 12) | (INIT_PM << 6));
      model_init();
      #2 RST = 1'b1;
      idle(1);

      // 1: all-zero symbols, no frame_start after reset, with idle gaps
      v0 = n_valid; d0 = n_done;
      for (int i = 0; i < 64; i++) begin
         issue(0, 1, 0, 1, 1, 2);
         if (i == 0) check("zero_sym_step0", int'(survivor), 0);
         check("pm0_zero", int'(dut.pm_q[0]), 0);
         idle(int'($urandom_range(0, 2)));
      end
      idle(2);
      check("p1_valid_count", n_valid - v0, 64);
      check("p1_done_count", n_done - d0, 1);

      // 2: error-free encoded 1,0,1,1
      issue(1, 0, 0, 0, 0, 0);
      check("fs_alone_no_valid", int'(survivor_valid), 0);
      for (int i = 0; i < 4; i++) begin
         issue(0, 1, hd(syms[i], 0), hd(syms[i], 1), hd(syms[i], 2), hd(syms[i], 3));
         check("true_state_pm", int'(dut.pm_q[truth[i]]), 0);
`ifdef ACS_BEST_STATE_EN
         check("best_seq", int'(best_state), truth[i]);
`else
         check("best_tied", int'(best_state), 0);
`endif
      end
      idle(1);

      // 3: ties from init metrics
      for (int i = 0; i < 3; i++) issue(0, 1, 1, 1, 1, 1);
      issue(1, 1, 1, 1, 1, 1);
      check("tie_valid", int'(survivor_valid), 1);
      check("tie_survivor", int'(survivor), 0);
      idle(1);

      // 4: bm_11=2 throughout, metrics forced upward into normalisation
      issue(1, 0, 0, 0, 0, 0);
      ne0 = norm_events;
      for (int i = 0; i < 64; i++) begin
         issue(0, 1, int'($urandom_range(1, 2)), int'($urandom_range(1, 2)),
               int'($urandom_range(1, 2)), 2);
      end
      idle(2);
      check("norm_event_seen", int'(norm_events > ne0), 1);

      // 5: asynchronous reset at step 20
      issue(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) rand_step();
      #2 RST = 1'b0;
      #1;
      check("async_rst_survivor", int'(survivor), 0);
      check("async_rst_valid", int'(survivor_valid), 0);
      check("async_rst_done", int'(frame_done), 0);
      check("async_rst_best", int'(best_state), 0);
      check("async_rst_pm", pm_vec(), (INIT_PM << 18) | (INIT_PM << 12) | (INIT_PM << 6));
      sb.delete();
      model_init();
      idle(1);
      RST = 1'b1;
      idle(1);
      v0 = n_valid; d0 = n_done;
      for (int i = 0; i < 64; i++) begin
         rand_step();
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(2);
      check("p5_valid_count", n_valid - v0, 64);
      check("p5_done_count", n_done - d0, 1);

      // 6: frame_start with path_enable, then back-to-back steps
      v0 = n_valid; d0 = n_done;
      begin
         int r;
         r = int'($urandom_range(0, 3));
         issue(1, 1, hd(r, 0), hd(r, 1), hd(r, 2), hd(r, 3));
      end
      for (int i = 1; i < 64; i++) rand_step();
      idle(3);
      check("p6_valid_count", n_valid - v0, 64);
      check("p6_done_count", n_done - d0, 1);
      check("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
